// File: rtl/affine_acc_if.sv
// Valid/ready streams around the accumulator: partial sums with bias in, activations out.
// The slave modport is the accumulator's view and the master modport is the producer/consumer view.
interface affine_acc_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
) ();
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic [IN_W-1:0]  bias_in;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, bias_in, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, bias_in, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/affine_acc.sv
// Tiled affine-layer accumulator: sums num_tiles partial sums plus a bias per neuron,
// then applies shift, ReLU and unsigned saturation before handing off one activation.
module affine_acc #(
    parameter int IN_W  = 12,
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tiles,
    input  logic [CNT_W-1:0] num_outputs,
    output logic             busy,
    output logic             done,
    affine_acc_if.slave      io
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [ACC_W:0]   ACC_MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
    localparam logic signed [ACC_W:0]   ACC_MIN = (ACC_W+1)'(-(2**(ACC_W-1)));
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2**OUT_W - 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        tile_cnt;
    logic [CNT_W-1:0]        neuron_cnt;
    logic [CNT_W-1:0]        tiles;
    logic [CNT_W-1:0]        outputs;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    beat;
    logic signed [ACC_W:0]   base;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] acc_new;
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        act;

    assign beat         = io.in_valid & in_ready_q;
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_last  = out_last_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // One guard bit above the accumulator lets the sum be clamped instead of wrapping;
    // the first tile of a neuron starts from the bias rather than the stale accumulator.
    always_comb begin
        base     = (tile_cnt == '0) ? (ACC_W+1)'($signed(io.bias_in)) : (ACC_W+1)'(acc);
        sum_wide = base + (ACC_W+1)'($signed(io.in_data));
        if (sum_wide > ACC_MAX) begin
            acc_new = ACC_W'(ACC_MAX);
        end else if (sum_wide < ACC_MIN) begin
            acc_new = ACC_W'(ACC_MIN);
        end else begin
            acc_new = sum_wide[ACC_W-1:0];
        end
        shifted = acc_new >>> SHIFT;
        if (shifted < 0) begin
            act = '0;
        end else if (shifted > OUT_MAX) begin
            act = '1;
        end else begin
            act = shifted[OUT_W-1:0];
        end
    end

    // Control FSM; handshake and status outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            tile_cnt    <= '0;
            neuron_cnt  <= '0;
            tiles       <= '0;
            outputs     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tiles      <= (num_tiles == '0) ? CNT_W'(1) : num_tiles;
                        outputs    <= (num_outputs == '0) ? CNT_W'(1) : num_outputs;
                        tile_cnt   <= '0;
                        neuron_cnt <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc <= acc_new;
                        if (tile_cnt == tiles - CNT_W'(1)) begin
                            out_data_q  <= act;
                            out_last_q  <= (neuron_cnt == outputs - CNT_W'(1));
                            tile_cnt    <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= OUT;
                        end else begin
                            tile_cnt <= tile_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            neuron_cnt <= neuron_cnt + CNT_W'(1);
                            in_ready_q <= 1'b1;
                            state      <= ACC;
                        end
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
